pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer side of the OTTER 5-stage stall/flush protocol.
//  Takes stall requests from the hazard unit, the EX-stage redirect and memory ready handshakes.
//  Drives the PC write, all four pipeline-register enables/flushes and the redirect PC.
//  Buffers a redirect that arrives while IMEM is busy; keeps saturating stall/flush counters.
// PARAMETERS
//  CNT_W    32  width of the stall_cnt / flush_cnt performance counters
//  XLEN     32  PC width
// PORTS
//  clk            in   1     system clock, rising edge
//  rst            in   1     asynchronous, active-high reset
//  if_stall       in   1     load-use stall request (hazard unit, comb)
//  id_stall       in   1     branch-RAW stall request (hazard unit, comb)
//  redirect_valid in   1     EX resolved taken branch/jump this cycle
//  redirect_pc    in   XLEN  target PC for redirect
//  imem_ready     in   1     IMEM returns fetch this cycle
//  dmem_ready     in   1     DMEM access in MEM completes this cycle (1 when no access)
//  pc_we          out  1     PC register write enable
//  pc_sel_redir   out  1     PC mux selects pc_redir
//  pc_redir       out  XLEN  redirect PC (live or buffered)
//  if_id_en       out  1     IF/ID enable;  if_id_flush out 1 IF/ID load NOP
//  id_ex_en       out  1     ID/EX enable;  id_ex_flush out 1 ID/EX load NOP
//  ex_mem_en      out  1     EX/MEM enable
//  mem_wb_bubble  out  1     MEM/WB loads NOP (regWrite=0) instead of MEM result
//  stall_cnt      out  CNT_W cycles with pc_we=0, saturating
//  flush_cnt      out  CNT_W redirects applied, saturating
// BEHAVIOUR
//  Reset: state=RUN, pend_pc=0, counters=0; outputs decode from RUN with all inputs low.
//  Comb outputs from state+inputs; state, pend_pc, counters register on clk. Zero added latency.
//  FSM states: RUN, DMEM_WAIT, REDIR_PEND.
//  Priority per cycle (highest first): dmem stall > redirect > if_stall > id_stall > imem stall.
//  dmem_ready=0 (any state): pc_we=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, no flushes;
//   state->DMEM_WAIT (returns to prior RUN/REDIR_PEND when dmem_ready=1; pending redirect kept).
//   A redirect_valid seen while frozen is ignored: EX is held, re-presented after release.
//  redirect_valid=1, imem_ready=1: pc_sel_redir=1, pc_redir=redirect_pc, pc_we=1,
//   if_id_flush=id_ex_flush=1, flush_cnt+1. Overrides if_stall/id_stall (stalled instrs are squashed).
//  redirect_valid=1, imem_ready=0: pend_pc<=redirect_pc, ->REDIR_PEND, flush IF/ID+ID/EX, pc_we=0.
//  REDIR_PEND: pc_redir=pend_pc; when imem_ready=1: pc_we=1, pc_sel_redir=1, if_id_flush=1,
//   flush_cnt+1, ->RUN. New redirect_valid in REDIR_PEND overwrites pend_pc (younger cannot exist).
//  if_stall=1: pc_we=0, if_id_en=0, id_ex_flush=1 (bubble into EX), ex_mem_en=1.
//  id_stall=1: same response as if_stall.
//  imem_ready=0, no other event: pc_we=0, if_id_flush=1, downstream advances.
//  Flush wins over enable: flush asserted => reg loads NOP regardless of *_en.
//  Counters saturate at all-ones, no wrap. stall_cnt increments every cycle pc_we=0.
//  Reset mid-stall or mid REDIR_PEND: pending redirect discarded, back to RUN immediately.
// STRUCTURE
//  Package otter_pipe_pkg: typedef enum logic[1:0] {RUN,DMEM_WAIT,REDIR_PEND} stall_state_t;
//   localparam NOP_INSTR = 32'h0000_0013; struct stage_ctrl_t {en, flush}.
//  One sub-module: sat_counter #(CNT_W) (inc, clr) instantiated twice for stall/flush counts.
// TESTING
//  Load-use: if_stall=1 one cycle -> pc_we=0, if_id_en=0, id_ex_flush=1, stall_cnt 0->1.
//  Redirect + id_stall same cycle, redirect_pc=0x100 -> pc_we=1, pc_redir=0x100, both flushes, flush_cnt=1.
//  Redirect 0x200 with imem_ready=0 for 3 cycles -> REDIR_PEND, pc_we=0 x3; 4th cycle pc=0x200, ->RUN.
//  dmem_ready=0 for 2 cycles during REDIR_PEND -> all en=0, mem_wb_bubble=1, pend_pc held, then resumes.
//  Force stall_cnt to 2^CNT_W-2, stall 3 cycles -> saturates at all-ones, no wrap.
//  Assert rst async in REDIR_PEND (mid-cycle) -> state=RUN, counters=0 before next edge, no redirect.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER 5-stage pipeline stall/flush control.
package otter_pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DMEM_WAIT  = 2'd1,
        REDIR_PEND = 2'd2
    } stall_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    function automatic stage_ctrl_t stage_ctrl(input logic en, input logic flush);
        stage_ctrl_t c;
        c.en    = en;
        c.flush = flush;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// OTTER pipeline stall/flush consumer: decodes hazard, redirect and memory handshakes
// into PC/pipeline-register controls, buffering a redirect that meets a busy IMEM.
module pipeline_stall_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall,
    input  logic             id_stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             pc_sel_redir,
    output logic [XLEN-1:0]  pc_redir,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stall_state_t    state_q, state_d;
    stall_state_t    ret_q, ret_d;
    stall_state_t    eff_state;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pending;
    logic            redir_applied;
    stage_ctrl_t     if_id_c, id_ex_c;

    // DMEM_WAIT behaves as the state it froze, so release costs no extra cycle.
    always_comb begin
        eff_state     = (state_q == DMEM_WAIT) ? ret_q : state_q;
        pending       = (eff_state == REDIR_PEND);
        state_d       = eff_state;
        ret_d         = ret_q;
        pend_pc_d     = pend_pc_q;
        pc_we         = 1'b1;
        pc_sel_redir  = 1'b0;
        pc_redir      = (pending && !(redirect_valid && dmem_ready)) ? pend_pc_q : redirect_pc;
        if_id_c       = stage_ctrl(1'b1, 1'b0);
        id_ex_c       = stage_ctrl(1'b1, 1'b0);
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        redir_applied = 1'b0;

        if (!dmem_ready) begin
            pc_we         = 1'b0;
            if_id_c       = stage_ctrl(1'b0, 1'b0);
            id_ex_c       = stage_ctrl(1'b0, 1'b0);
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_d       = DMEM_WAIT;
            ret_d         = eff_state;
        end else if (redirect_valid) begin
            if_id_c.flush = 1'b1;
            id_ex_c.flush = 1'b1;
            if (imem_ready) begin
                pc_sel_redir  = 1'b1;
                redir_applied = 1'b1;
                state_d       = RUN;
            end else begin
                pc_we     = 1'b0;
                pend_pc_d = redirect_pc;
                state_d   = REDIR_PEND;
            end
        end else if (pending && imem_ready) begin
            pc_sel_redir  = 1'b1;
            if_id_c.flush = 1'b1;
            redir_applied = 1'b1;
            state_d       = RUN;
        end else if (if_stall || id_stall) begin
            pc_we         = 1'b0;
            if_id_c.en    = 1'b0;
            id_ex_c.flush = 1'b1;
        end else if (!imem_ready) begin
            pc_we         = 1'b0;
            if_id_c.flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            ret_q     <= RUN;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign if_id_en    = if_id_c.en;
    assign if_id_flush = if_id_c.flush;
    assign id_ex_en    = id_ex_c.en;
    assign id_ex_flush = id_ex_c.flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!pc_we),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redir_applied),
        .clr (1'b0),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized self-checking bench for pipeline_stall_ctrl against a pending-redirect rule model.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 8;
    localparam int XLEN  = 32;
    localparam longint CMAX = (longint'(1) << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             if_stall, id_stall, redirect_valid, imem_ready, dmem_ready;
    logic [XLEN-1:0]  redirect_pc;
    logic             pc_we, pc_sel_redir, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic             ex_mem_en, mem_wb_bubble;
    logic [XLEN-1:0]  pc_redir;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    bit          m_pend;
    logic [31:0] m_pend_pc;
    longint      m_stall, m_flush;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall       (if_stall),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_ready     (imem_ready),
        .dmem_ready     (dmem_ready),
        .pc_we          (pc_we),
        .pc_sel_redir   (pc_sel_redir),
        .pc_redir       (pc_redir),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_bubble  (mem_wb_bubble),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    // Called one time unit after a rising edge; checks at the falling edge, then advances the model.
    task automatic step(input logic ifs, input logic ids, input logic rv,
                        input logic [31:0] rpc, input logic imr, input logic dmr);
        logic e_we, e_sel, e_ifen, e_iffl, e_exen, e_exfl, e_memen, e_bub, applied;
        logic [31:0] e_redir;
        bit n_pend;
        logic [31:0] n_pc;
        if_stall = ifs; id_stall = ids; redirect_valid = rv;
        redirect_pc = rpc; imem_ready = imr; dmem_ready = dmr;

        e_we = 1; e_sel = 0; e_ifen = 1; e_iffl = 0; e_exen = 1; e_exfl = 0;
        e_memen = 1; e_bub = 0; applied = 0;
        e_redir = (m_pend && !(rv && dmr)) ? m_pend_pc : rpc;
        n_pend = m_pend; n_pc = m_pend_pc;
        if (!dmr) begin
            e_we = 0; e_ifen = 0; e_exen = 0; e_memen = 0; e_bub = 1;
        end else if (rv && imr) begin
            e_sel = 1; e_iffl = 1; e_exfl = 1; applied = 1; n_pend = 0;
        end else if (rv) begin
            e_we = 0; e_iffl = 1; e_exfl = 1; n_pend = 1; n_pc = rpc;
        end else if (m_pend && imr) begin
            e_sel = 1; e_iffl = 1; applied = 1; n_pend = 0;
        end else if (ifs || ids) begin
            e_we = 0; e_ifen = 0; e_exfl = 1;
        end else if (!imr) begin
            e_we = 0; e_iffl = 1;
        end

        #4;
        chk("pc_we",         pc_we,         e_we);
        chk("pc_sel_redir",  pc_sel_redir,  e_sel);
        chk("pc_redir",      pc_redir,      e_redir);
        chk("if_id_en",      if_id_en,      e_ifen);
        chk("if_id_flush",   if_id_flush,   e_iffl);
        chk("id_ex_en",      id_ex_en,      e_exen);
        chk("id_ex_flush",   id_ex_flush,   e_exfl);
        chk("ex_mem_en",     ex_mem_en,     e_memen);
        chk("mem_wb_bubble", mem_wb_bubble, e_bub);
        chk("stall_cnt",     stall_cnt,     m_stall);
        chk("flush_cnt",     flush_cnt,     m_flush);

        @(posedge clk);
        m_pend = n_pend; m_pend_pc = n_pc;
        if (!e_we && m_stall < CMAX) m_stall++;
        if (applied && m_flush < CMAX) m_flush++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_stall = 0; id_stall = 0; redirect_valid = 0; imem_ready = 0; dmem_ready = 0;
        redirect_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_stall = 0; id_stall = 0; redirect_valid = 0; imem_ready = 0; dmem_ready = 0;
        redirect_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_we",     pc_we,         1'b0);
        chk("rst_bubble",    mem_wb_bubble, 1'b1);
        chk("rst_if_flush",  if_id_flush,   1'b0);
        chk("rst_stall_cnt", stall_cnt,     0);
        chk("rst_flush_cnt", flush_cnt,     0);
        rst = 1'b0;

        // Load-use stall
        step(0, 0, 0, 32'h0, 1, 1);
        step(1, 0, 0, 32'h0, 1, 1);
        chk("lu_stall_cnt", stall_cnt, 1);

        // Redirect beats a simultaneous branch-RAW stall
        step(0, 1, 1, 32'h100, 1, 1);
        chk("rd_flush_cnt", flush_cnt, 1);

        // Redirect while IMEM busy for three cycles, applied on the fourth
        step(0, 0, 1, 32'h200, 0, 1);
        step(0, 0, 0, 32'h0, 0, 1);
        step(0, 0, 0, 32'h0, 0, 1);
        step(0, 0, 0, 32'h0, 1, 1);
        chk("pend_flush_cnt", flush_cnt, 2);
        chk("pend_stall_cnt", stall_cnt, 4);

        // DMEM freeze in the middle of a pending redirect
        step(0, 0, 1, 32'h300, 0, 1);
        step(0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 1, 32'h0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 1);
        step(0, 0, 0, 32'h0, 1, 1);
        chk("frz_flush_cnt", flush_cnt, 3);

        // Asynchronous reset while a redirect is pending
        step(0, 0, 1, 32'h400, 0, 1);
        if_stall = 0; id_stall = 0; redirect_valid = 0;
        redirect_pc = 32'h55; imem_ready = 1; dmem_ready = 1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall_cnt", stall_cnt,    0);
        chk("arst_flush_cnt", flush_cnt,    0);
        chk("arst_sel",       pc_sel_redir, 1'b0);
        chk("arst_pc_redir",  pc_redir,     32'h55);
        chk("arst_pc_we",     pc_we,        1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 32'h66, 1, 1);

        // Stall counter saturation
        do_reset();
        repeat (254) step(1, 0, 0, 32'h0, 1, 1);
        chk("sat_at_max_m1", stall_cnt, 254);
        repeat (3) step(0, 1, 0, 32'h0, 1, 1);
        chk("sat_at_max", stall_cnt, 255);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 2, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
